// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction control sequencer: opcodes, FSM states
// and the width of the per-step settle counter.
package ctrl_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b100;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_PC,
        S_DONE
    } state_t;

    function automatic logic uses_rs(input logic [2:0] op);
        return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic uses_rd(input logic [2:0] op);
        return (op == OP_MOV) || (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// Binary register index to one-hot select, with a flag telling whether the
// index names a register that actually exists.
module reg_sel_dec #(
    parameter int NREGS = 8,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [NREGS-1:0] o_onehot,
    output logic             o_in_range
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            o_onehot[i] = (32'(i_idx) == i);
        end
    end

    assign o_in_range = (32'(i_idx) < NREGS);

endmodule

// File: rtl/instr_ctrl_fsm.sv
// Multi-instruction control sequencer: turns one decoded instruction into a
// timed series of single-driver bus transfers, then a PC increment and done.
module instr_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int SETTLE = 1,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [2:0]       i_opcode,
    input  logic [IDX_W-1:0] i_rd,
    input  logic [IDX_W-1:0] i_rs,
    output logic [NREGS-1:0] o_reg_out_en,
    output logic [NREGS-1:0] o_reg_load,
    output logic             o_imm_out,
    output logic             o_a_load,
    output logic             o_g_load,
    output logic             o_g_out,
    output logic             o_alu_sub,
    output logic             o_pc_inc,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [2:0]         r_op;
    logic [IDX_W-1:0]   r_rd;
    logic [IDX_W-1:0]   r_rs;

    logic [2:0]         w_sel_op;
    logic [IDX_W-1:0]   w_sel_rd;
    logic [IDX_W-1:0]   w_sel_rs;
    logic [NREGS-1:0]   w_rd_oh;
    logic [NREGS-1:0]   w_rs_oh;
    logic               w_rd_ok;
    logic               w_rs_ok;
    logic               w_illegal;
    logic               w_last;
    logic               w_is_alu;

    // In IDLE the decoders look at the incoming fields so legality is known on
    // the accept edge; afterwards they follow the latched copies.
    assign w_sel_op = (r_state == S_IDLE) ? i_opcode : r_op;
    assign w_sel_rd = (r_state == S_IDLE) ? i_rd     : r_rd;
    assign w_sel_rs = (r_state == S_IDLE) ? i_rs     : r_rs;

    reg_sel_dec #(.NREGS(NREGS), .IDX_W(IDX_W)) u_rd_dec (
        .i_idx      (w_sel_rd),
        .o_onehot   (w_rd_oh),
        .o_in_range (w_rd_ok)
    );

    reg_sel_dec #(.NREGS(NREGS), .IDX_W(IDX_W)) u_rs_dec (
        .i_idx      (w_sel_rs),
        .o_onehot   (w_rs_oh),
        .o_in_range (w_rs_ok)
    );

    assign w_illegal = (w_sel_op > OP_NOP)
                     || (uses_rd(w_sel_op) && !w_rd_ok)
                     || (uses_rs(w_sel_op) && !w_rs_ok);

    assign w_last   = (r_cnt == CNT_W'(SETTLE - 1));
    assign w_is_alu = (r_op == OP_ADD) || (r_op == OP_SUB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if ((r_state == S_IDLE) && i_start) begin
                r_op <= i_opcode;
                r_rd <= i_rd;
                r_rs <= i_rs;
            end
        end
    end

    // Illegal instructions and NOP skip straight to the PC step.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (w_illegal || (i_opcode == OP_NOP)) ? S_PC : S_T1;
                end
            end
            S_T1: begin
                if (w_last) begin
                    w_next_state = w_is_alu ? S_T2 : S_PC;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_T2: begin
                if (w_last) begin
                    w_next_state = S_T3;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_T3: begin
                if (w_last) begin
                    w_next_state = S_PC;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_PC:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Out-enables span the whole step; loads fire only on its last cycle.
    always_comb begin
        o_reg_out_en = '0;
        o_reg_load   = '0;
        o_imm_out    = 1'b0;
        o_a_load     = 1'b0;
        o_g_load     = 1'b0;
        o_g_out      = 1'b0;
        o_alu_sub    = 1'b0;
        o_pc_inc     = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_T1: begin
                if (w_is_alu) begin
                    o_reg_out_en = w_rd_oh;
                    o_a_load     = w_last;
                end else if (r_op == OP_LDI) begin
                    o_imm_out  = 1'b1;
                    o_reg_load = w_last ? w_rd_oh : '0;
                end else begin
                    o_reg_out_en = w_rs_oh;
                    o_reg_load   = w_last ? w_rd_oh : '0;
                end
            end
            S_T2: begin
                o_reg_out_en = w_rs_oh;
                o_g_load     = w_last;
                o_alu_sub    = (r_op == OP_SUB);
            end
            S_T3: begin
                o_g_out    = 1'b1;
                o_reg_load = w_last ? w_rd_oh : '0;
            end
            S_PC:   o_pc_inc = 1'b1;
            S_DONE: begin
                o_done = 1'b1;
                o_err  = w_illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Self-checking bench for instr_ctrl_fsm: three instances with different settle
// times, each instruction compared cycle by cycle against a step-list model.
module tb_instr_ctrl_fsm;

    typedef struct packed {
        logic [7:0] outEn;
        logic [7:0] load;
        logic       imm;
        logic       aLoad;
        logic       gLoad;
        logic       gOut;
        logic       sub;
        logic       pc;
        logic       done;
        logic       err;
        logic       busy;
    } obs_t;

    localparam int K_REG = 0;
    localparam int K_IMM = 1;
    localparam int K_A   = 2;
    localparam int K_G   = 3;

    int settleOf [3] = '{1, 2, 3};
    int maxIdx   [3] = '{7, 7, 15};

    logic       clk;
    logic       reset;
    logic       start  [3];
    logic [2:0] opcode [3];
    logic [3:0] rd     [3];
    logic [3:0] rs     [3];

    logic [7:0] regOutEn [3];
    logic [7:0] regLoad  [3];
    logic       immOut   [3];
    logic       aLoad    [3];
    logic       gLoad    [3];
    logic       gOut     [3];
    logic       aluSub   [3];
    logic       pcInc    [3];
    logic       done     [3];
    logic       err      [3];
    logic       busy     [3];

    int   checkCount = 0;
    int   errorCount = 0;
    obs_t expQ [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_ctrl_fsm #(.NREGS(8), .SETTLE(1)) dut0 (
        .clk(clk), .reset(reset), .i_start(start[0]), .i_opcode(opcode[0]),
        .i_rd(rd[0][2:0]), .i_rs(rs[0][2:0]),
        .o_reg_out_en(regOutEn[0]), .o_reg_load(regLoad[0]), .o_imm_out(immOut[0]),
        .o_a_load(aLoad[0]), .o_g_load(gLoad[0]), .o_g_out(gOut[0]), .o_alu_sub(aluSub[0]),
        .o_pc_inc(pcInc[0]), .o_done(done[0]), .o_err(err[0]), .o_busy(busy[0])
    );

    instr_ctrl_fsm #(.NREGS(8), .SETTLE(2)) dut1 (
        .clk(clk), .reset(reset), .i_start(start[1]), .i_opcode(opcode[1]),
        .i_rd(rd[1][2:0]), .i_rs(rs[1][2:0]),
        .o_reg_out_en(regOutEn[1]), .o_reg_load(regLoad[1]), .o_imm_out(immOut[1]),
        .o_a_load(aLoad[1]), .o_g_load(gLoad[1]), .o_g_out(gOut[1]), .o_alu_sub(aluSub[1]),
        .o_pc_inc(pcInc[1]), .o_done(done[1]), .o_err(err[1]), .o_busy(busy[1])
    );

    instr_ctrl_fsm #(.NREGS(8), .SETTLE(3), .IDX_W(4)) dut2 (
        .clk(clk), .reset(reset), .i_start(start[2]), .i_opcode(opcode[2]),
        .i_rd(rd[2]), .i_rs(rs[2]),
        .o_reg_out_en(regOutEn[2]), .o_reg_load(regLoad[2]), .o_imm_out(immOut[2]),
        .o_a_load(aLoad[2]), .o_g_load(gLoad[2]), .o_g_out(gOut[2]), .o_alu_sub(aluSub[2]),
        .o_pc_inc(pcInc[2]), .o_done(done[2]), .o_err(err[2]), .o_busy(busy[2])
    );

    function automatic obs_t sampleDut(input int inst);
        obs_t o;
        o.outEn = regOutEn[inst];
        o.load  = regLoad[inst];
        o.imm   = immOut[inst];
        o.aLoad = aLoad[inst];
        o.gLoad = gLoad[inst];
        o.gOut  = gOut[inst];
        o.sub   = aluSub[inst];
        o.pc    = pcInc[inst];
        o.done  = done[inst];
        o.err   = err[inst];
        o.busy  = busy[inst];
        return o;
    endfunction

    // Reference: list the bus transfers the instruction needs, stretch each one
    // over the settle time, then append the PC and DONE cycles.
    task automatic buildTrace(input int settle, input int op, input int dRd, input int dRs);
        obs_t w;
        bit   legal;
        int   nSteps;
        int   srcKind [3];
        int   srcIdx  [3];
        int   dstKind [3];
        int   dstIdx  [3];
        expQ.delete();
        nSteps = 0;
        legal = (op <= 4) && (op == 4 || op == 1 || dRs < 8) && (op == 4 || dRd < 8);
        if (legal) begin
            case (op)
                0: begin
                    srcKind[0] = K_REG; srcIdx[0] = dRs; dstKind[0] = K_REG; dstIdx[0] = dRd;
                    nSteps = 1;
                end
                1: begin
                    srcKind[0] = K_IMM; srcIdx[0] = 0; dstKind[0] = K_REG; dstIdx[0] = dRd;
                    nSteps = 1;
                end
                2, 3: begin
                    srcKind[0] = K_REG; srcIdx[0] = dRd; dstKind[0] = K_A;   dstIdx[0] = 0;
                    srcKind[1] = K_REG; srcIdx[1] = dRs; dstKind[1] = K_G;   dstIdx[1] = 0;
                    srcKind[2] = K_G;   srcIdx[2] = 0;   dstKind[2] = K_REG; dstIdx[2] = dRd;
                    nSteps = 3;
                end
                default: nSteps = 0;
            endcase
        end
        for (int s = 0; s < nSteps; s++) begin
            for (int k = 0; k < settle; k++) begin
                w = '0;
                w.busy = 1'b1;
                if (srcKind[s] == K_REG) w.outEn[srcIdx[s]] = 1'b1;
                if (srcKind[s] == K_IMM) w.imm = 1'b1;
                if (srcKind[s] == K_G)   w.gOut = 1'b1;
                if (dstKind[s] == K_G && op == 3) w.sub = 1'b1;
                if (k == settle - 1) begin
                    if (dstKind[s] == K_REG) w.load[dstIdx[s]] = 1'b1;
                    if (dstKind[s] == K_A)   w.aLoad = 1'b1;
                    if (dstKind[s] == K_G)   w.gLoad = 1'b1;
                end
                expQ.push_back(w);
            end
        end
        w = '0; w.busy = 1'b1; w.pc = 1'b1;
        expQ.push_back(w);
        w = '0; w.busy = 1'b1; w.done = 1'b1; w.err = !legal;
        expQ.push_back(w);
    endtask

    task automatic setInputs(input int inst, input logic st, input int op, input int dRd, input int dRs);
        start[inst]  = st;
        opcode[inst] = 3'(op);
        rd[inst]     = 4'(dRd);
        rs[inst]     = 4'(dRs);
    endtask

    // Issue one instruction and compare every cycle until IDLE returns; with
    // noisyStart, start is toggled while busy and must be ignored.
    task automatic runInstr(input int inst, input int op, input int dRd, input int dRs,
                            input string name, input bit noisyStart);
        obs_t got;
        obs_t idleWord;
        int   doneSeen;
        buildTrace(settleOf[inst], op, dRd, dRs);
        idleWord = '0;
        doneSeen = 0;
        @(negedge clk);
        setInputs(inst, 1'b1, op, dRd, dRs);
        @(posedge clk);
        #1 setInputs(inst, 1'b0, op, dRd, dRs);
        for (int c = 0; c < expQ.size(); c++) begin
            @(negedge clk);
            got = sampleDut(inst);
            if (got.done) doneSeen++;
            checkCount++;
            if (got !== expQ[c]) begin
                errorCount++;
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c + 1, got, expQ[c]);
            end
            if (noisyStart) begin
                if (c < expQ.size() - 1) setInputs(inst, 1'($urandom_range(0, 1)), 0, 1, 2);
                else                     setInputs(inst, 1'b0, 0, 1, 2);
            end
        end
        for (int c = 0; c < (noisyStart ? 3 : 1); c++) begin
            @(negedge clk);
            got = sampleDut(inst);
            if (got.done) doneSeen++;
            checkCount++;
            if (got !== idleWord) begin
                errorCount++;
                $display("[TB] FAIL %s idle: got %h expected %h", name, got, idleWord);
            end
        end
        if (noisyStart) begin
            checkCount++;
            if (doneSeen != 1) begin
                errorCount++;
                $display("[TB] FAIL %s done count: got %0d expected 1", name, doneSeen);
            end
        end
    endtask

    task automatic test_reset();
        obs_t got;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = sampleDut(i);
            checkCount++;
            if (got !== obs_t'(0)) begin
                errorCount++;
                $display("[TB] FAIL reset dut%0d: got %h expected 0", i, got);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_mov();
        runInstr(0, 0, 3, 5, "mov_s1", 1'b0);
    endtask

    task automatic test_add();
        runInstr(1, 2, 1, 2, "add_s2", 1'b0);
        runInstr(1, 3, 6, 0, "sub_s2", 1'b0);
    endtask

    task automatic test_illegal();
        runInstr(2, 3, 2, 9, "sub_rs9", 1'b0);
        runInstr(2, 6, 1, 1, "op110", 1'b0);
        runInstr(2, 1, 12, 3, "ldi_rd12", 1'b0);
        runInstr(2, 4, 15, 15, "nop_wide", 1'b0);
        runInstr(2, 2, 7, 7, "add_edge", 1'b0);
    endtask

    task automatic test_start_ignored();
        runInstr(0, 1, 0, 0, "ldi_noisy_s1", 1'b1);
        runInstr(1, 1, 0, 0, "ldi_noisy_s2", 1'b1);
    endtask

    task automatic test_reset_mid();
        obs_t got;
        buildTrace(settleOf[1], 2, 1, 2);
        @(negedge clk);
        setInputs(1, 1'b1, 2, 1, 2);
        @(posedge clk);
        #1 setInputs(1, 1'b0, 2, 1, 2);
        @(negedge clk);
        got = sampleDut(1);
        checkCount++;
        if (got !== expQ[0]) begin
            errorCount++;
            $display("[TB] FAIL rstmid cycle1: got %h expected %h", got, expQ[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        got = sampleDut(1);
        checkCount++;
        if (got !== obs_t'(0)) begin
            errorCount++;
            $display("[TB] FAIL rstmid after reset: got %h expected 0", got);
        end
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            got = sampleDut(1);
            checkCount++;
            if (got !== obs_t'(0)) begin
                errorCount++;
                $display("[TB] FAIL rstmid quiet %0d: got %h expected 0", c, got);
            end
        end
        runInstr(1, 0, 4, 6, "mov_after_rst", 1'b0);
    endtask

    task automatic test_back_to_back();
        obs_t got;
        obs_t want;
        @(negedge clk);
        setInputs(0, 1'b1, 4, 0, 0);
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            want = '0;
            if (c % 3 != 0) want.busy = 1'b1;
            if (c % 3 == 1) want.pc   = 1'b1;
            if (c % 3 == 2) want.done = 1'b1;
            got = sampleDut(0);
            checkCount++;
            if (got !== want) begin
                errorCount++;
                $display("[TB] FAIL b2b cycle %0d: got %h expected %h", c, got, want);
            end
            if (c == 9) setInputs(0, 1'b0, 4, 0, 0);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int inst;
        int op;
        for (int n = 0; n < 60; n++) begin
            inst = int'($urandom_range(0, 2));
            op   = int'($urandom_range(0, 7));
            runInstr(inst, op, int'($urandom_range(0, maxIdx[inst])),
                     int'($urandom_range(0, maxIdx[inst])), "random", 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) setInputs(i, 1'b0, 0, 0, 0);
        reset = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_mov();
        test_add();
        test_illegal();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instr_ctrl_fsm.md
# instr_ctrl_fsm

Parametrised multi-instruction control sequencer for the simple bus-based processor datapath. It accepts one decoded instruction per `start` handshake and drives one-hot register bus-out and load enables, the A/G register enables, the ALU operation, PC increment and a completion pulse. It supports MOV, LDI, ADD, SUB and NOP, with a programmable bus-settle time per transfer. It supersedes the single-purpose MOV sequencer and sits between instruction decode and the register-file/ALU datapath.

## Interface
- `NREGS`, 8: number of general registers; range 2..16.
- `SETTLE`, 1: cycles per bus-transfer step; range 1..15.
- `IDX_W`, $clog2(NREGS): register index width; derived, do not override.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: instruction valid; sampled only in IDLE.
- `opcode` in 3: 000 MOV, 001 LDI, 010 ADD, 011 SUB, 100 NOP; 101–111 illegal.
- `rd`, `rs` in IDX_W: destination and source register indices.
- `reg_out_en` out NREGS: one-hot, gates the register onto the bus.
- `reg_load` out NREGS: one-hot, loads the register from the bus.
- `imm_out` out 1: immediate driver onto the bus (LDI).
- `a_load`, `g_load`, `g_out` out 1: A register load, G register load, G register onto the bus.
- `alu_sub` out 1: 0 = add, 1 = subtract; valid while `g_load` is high.
- `pc_inc`, `done`, `err`, `busy` out 1: see Operation.

## Operation
- States: IDLE, T1, T2, T3, PC, DONE.
- In IDLE with `start`=1, the block latches `opcode`, `rd` and `rs` on that edge (the accept edge). Fields are held internally until return to IDLE.
- Transfer steps per opcode (out-enable / load):
  - MOV: T1 = `reg_out_en[rs]` / `reg_load[rd]`.
  - LDI: T1 = `imm_out` / `reg_load[rd]`.
  - ADD/SUB: T1 = `reg_out_en[rd]` / `a_load`; T2 = `reg_out_en[rs]` / `g_load` with `alu_sub` = (op==SUB); T3 = `g_out` / `reg_load[rd]`.
  - NOP: no transfer steps.
- After the last step the FSM moves to PC (`pc_inc`=1 for one cycle), then DONE (`done`=1 for one cycle), then IDLE.
- Each step lasts exactly SETTLE cycles.
  - The out-enable is held for all SETTLE cycles.
  - The load enable (`reg_load`, `a_load`, `g_load`) is high only in the final cycle of the step.
  - `alu_sub` is held for the whole of T2.
- Illegal operand or opcode: `rd` ≥ NREGS, `rs` ≥ NREGS (when used), or opcode 101–111.
  - All transfer steps are skipped; no load or out-enable is asserted.
  - PC and DONE still occur.
  - `err`=1 in the DONE cycle only.
- At most one bit of `reg_out_en`, `imm_out` and `g_out` combined is high in any cycle (single bus driver).
- `busy`=1 in every state except IDLE. `start` is ignored while busy.
- All outputs are Moore outputs decoded from registered state, the step counter and the latched fields.

## Timing
- Reset: `reset`=0 at an edge forces IDLE, clears the step counter and latched fields, and sets all outputs to 0 from the next cycle. Reset mid-instruction aborts it with no further loads, `pc_inc` or `done`.
- Latency: N = number of transfer steps (MOV/LDI 1, ADD/SUB 3, NOP/illegal 0).
  - Cycle 1 is the cycle after the accept edge.
  - `pc_inc` is high in cycle N·SETTLE+1.
  - `done` is high in cycle N·SETTLE+2.
  - IDLE resumes in cycle N·SETTLE+3.
- Back-to-back: `start` held high through DONE is accepted in the first IDLE cycle. The minimum issue interval is N·SETTLE+3 cycles.
- Step counter: width 4 bits; counts 0..SETTLE-1 and wraps to 0 on each step change.

## Structure
- Package `ctrl_pkg`: opcode constants, state enum, step-counter width.
- Sub-module `reg_sel_dec`: binary index → NREGS-wide one-hot plus an `in_range` flag. Instantiate it twice (rd, rs).

## Test plan
- MOV with SETTLE=1, rd=3, rs=5: `reg_out_en`=0x20 and `reg_load`=0x08 in cycle 1; `pc_inc` in cycle 2; `done` in cycle 3; `busy` cycles 1–3.
- ADD with SETTLE=2, rd=1, rs=2:
  - `reg_out_en`=0x02 in cycles 1–2, with `a_load` in cycle 2 only.
  - `reg_out_en`=0x04 in cycles 3–4, with `g_load` in cycle 4 and `alu_sub`=0.
  - `g_out` in cycles 5–6, with `reg_load`=0x02 in cycle 6.
  - `pc_inc` in cycle 7; `done` in cycle 8.
- SUB with NREGS=8, rs=9 (index width widened in the bench) and opcode 110: no enables asserted; `pc_inc` in cycle 1; `done`+`err` in cycle 2.
- `start` pulsed during the busy cycles of LDI rd=0: ignored; exactly one `done`; `imm_out` and `reg_load`=0x01 in cycle 1.
- `reset`=0 in cycle 2 of an ADD: all outputs 0 the following cycle; no `done`; a new MOV accepted normally afterwards.
- `start` held high continuously with NOP: `done` in cycles 2, 5, 8 (interval 3).
